// File: rtl/sudoku_board_reader.sv
// rtl/sudoku_board_reader.sv - streams the 9x9 board from the store's read port, one byte per cell
// Define ASCII_OUT_EN for ASCII digits with a 0x0A byte closing every row.
module sudoku_board_reader #(
  parameter int N      = 9,
  parameter int CELL_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              rd_en,
  output logic [3:0]        rd_row,
  output logic [3:0]        rd_col,
  input  logic [CELL_W-1:0] rd_data,
  output logic [7:0]        out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last_col,
  output logic              out_last,
  output logic              busy,
  output logic              done
);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    CAPTURE,
    PRESENT,
`ifdef ASCII_OUT_EN
    NEWLINE,
`endif
    DONE
  } state_t;

  localparam logic [3:0] LAST = 4'(N - 1);

  state_t     state_q, state_d;
  logic [3:0] row_q, col_q;
  logic       xfer;

  assign xfer = out_valid & out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    rd_en     = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    done      = 1'b0;
    case (state_q)
      IDLE: begin
        busy = 1'b0;
        if (start) state_d = FETCH;
      end
      DONE: begin
        busy = 1'b0;
        done = 1'b1;
        if (start) state_d = FETCH;
      end
      FETCH: begin
        rd_en   = 1'b1;
        state_d = CAPTURE;
      end
      CAPTURE: state_d = PRESENT;
      PRESENT: begin
        out_valid = 1'b1;
        if (xfer) begin
`ifdef ASCII_OUT_EN
          state_d = (col_q == LAST) ? NEWLINE : FETCH;
`else
          state_d = (col_q == LAST && row_q == LAST) ? DONE : FETCH;
`endif
        end
      end
`ifdef ASCII_OUT_EN
      NEWLINE: begin
        out_valid = 1'b1;
        if (xfer) state_d = (row_q == LAST) ? DONE : FETCH;
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  // The address is the live cell counter, so it naturally holds its last value when idle.
  assign rd_row = row_q;
  assign rd_col = col_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row_q <= '0;
      col_q <= '0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            row_q <= '0;
            col_q <= '0;
          end
        end
        PRESENT: begin
          if (xfer && col_q != LAST) begin
            col_q <= col_q + 4'd1;
`ifndef ASCII_OUT_EN
          end else if (xfer && row_q != LAST) begin
            col_q <= '0;
            row_q <= row_q + 4'd1;
`endif
          end
        end
`ifdef ASCII_OUT_EN
        NEWLINE: begin
          if (xfer && row_q != LAST) begin
            col_q <= '0;
            row_q <= row_q + 4'd1;
          end
        end
`endif
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_data     <= '0;
      out_last_col <= 1'b0;
      out_last     <= 1'b0;
    end else if (state_q == CAPTURE) begin
`ifdef ASCII_OUT_EN
      out_data     <= (rd_data <= CELL_W'(9)) ? (8'h30 + 8'(rd_data)) : 8'h3F;
      out_last_col <= 1'b0;
      out_last     <= 1'b0;
`else
      out_data     <= 8'(rd_data);
      out_last_col <= (col_q == LAST);
      out_last     <= (col_q == LAST) && (row_q == LAST);
`endif
`ifdef ASCII_OUT_EN
    end else if (state_q == PRESENT && xfer && col_q == LAST) begin
      out_data     <= 8'h0A;
      out_last_col <= 1'b1;
      out_last     <= (row_q == LAST);
`endif
    end
  end

endmodule
